// File: rtl/bitdivider_pkg.sv
// Shared definitions for the bitdivider block: FSM state encoding, the
// operand/partial-remainder widths and the quotient reported on a
// divide-by-zero.
package bitdivider_pkg;

  localparam int DVD_W = 8;  // dividend / quotient width
  localparam int DVS_W = 4;  // divisor / remainder width
  localparam int REM_W = 5;  // partial remainder, one bit wider than the divisor

  localparam logic [DVD_W-1:0] DBZ_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitdivider_div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_in   - current partial remainder
//   bit_in   - next dividend bit (MSB first)
//   divisor  - latched divisor
//   rem_out  - partial remainder after shift/compare/subtract
//   q_bit    - quotient bit produced by this step
module div_step
  import bitdivider_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [REM_W-1:0] rem_out,
  output logic             q_bit
);

  logic [REM_W-1:0] shifted;
  logic             ge;

  // The partial remainder entering a step is always below the divisor, so
  // its top bit is zero and the shift cannot lose information. The top bit
  // is still folded into the compare so the step is correct on its own.
  assign shifted = {rem_in[REM_W-2:0], bit_in};
  assign ge      = rem_in[REM_W-1] | (shifted >= {1'b0, divisor});
  assign rem_out = ge ? (shifted - {1'b0, divisor}) : shifted;
  assign q_bit   = ge;

endmodule

// File: rtl/bitdivider.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n    - clock (rising edge) and asynchronous active-low reset
//   start         - begin a division; only honoured in IDLE
//   dividend      - 8-bit unsigned dividend, captured when start is accepted
//   divisor       - 4-bit unsigned divisor, captured when start is accepted
//   busy          - high while the 8 division steps run
//   done          - one-cycle pulse when results become valid
//   quotient      - 8-bit quotient (8'hFF on divide-by-zero)
//   remainder     - 4-bit remainder (0 on divide-by-zero)
//   div_by_zero   - set with done when the divisor was zero; held with results
module bitdivider
  import bitdivider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q;
  logic [DVD_W-1:0] dvd_sh_q;  // dividend, shifted left one bit per step
  logic [DVD_W-1:0] quo_sh_q;  // quotient bits collected so far
  logic [DVS_W-1:0] dvs_q;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_next;
  logic             q_bit;
  logic             last_step;

  div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_sh_q[DVD_W-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign last_step = (cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // done is a flop so it is a clean registered pulse aligned with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dvd_sh_q    <= '0;
      quo_sh_q    <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_sh_q <= dividend;
            dvs_q    <= divisor;
            rem_q    <= '0;
            quo_sh_q <= '0;
            cnt_q    <= '0;
            // Divide-by-zero skips RUN and publishes its fixed result now.
            if (divisor == '0) begin
              quotient    <= DBZ_QUOT;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_sh_q <= {dvd_sh_q[DVD_W-2:0], 1'b0};
          quo_sh_q <= {quo_sh_q[DVD_W-2:0], q_bit};
          rem_q    <= rem_next;
          cnt_q    <= cnt_q + 3'd1;
          if (last_step) begin
            quotient    <= {quo_sh_q[DVD_W-2:0], q_bit};
            remainder   <= rem_next[DVS_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bitdivider.md
BITDIVIDER -- requirements
Module: bitdivider

Interface
REQ-001 Parameters: none; all widths are fixed (8-bit dividend, 4-bit divisor).
REQ-002 clk  input  1  single clock for all state; rising-edge active.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend; sampled on the edge that accepts start.
REQ-006 divisor  input  4  unsigned divisor; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while a division is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 quotient  output  8  unsigned quotient.
REQ-010 remainder  output  4  unsigned remainder, always less than the divisor when div_by_zero=0.
REQ-011 div_by_zero  output  1  high with done when the latched divisor is 0; held with the results.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL, at the next edge, latch dividend and divisor, clear the partial remainder and step count, and enter RUN (or DONE if the divisor is 0).
REQ-014 RUN SHALL perform one restoring-division step per clock, MSB first.
- Shift the 5-bit partial remainder left, inserting the next dividend bit.
- If the partial remainder is >= divisor: subtract the divisor and set the quotient bit to 1.
- Otherwise: keep the partial remainder and set the quotient bit to 0.
REQ-015 RUN SHALL last exactly 8 cycles; the 8th step edge SHALL enter DONE and register done=1.
- Fixed latency: done is high in the cycle following the 9th rising edge after the accepting edge counted inclusively (accept edge k, steps on k+1..k+8, done high k+8..k+9).
REQ-016 DONE SHALL last one cycle and then return to IDLE unconditionally; done SHALL fall at that edge.
REQ-017 quotient, remainder and div_by_zero SHALL update only on the edge entering DONE and SHALL hold until the next entry to DONE or reset.
REQ-018 Division by zero: the accepting edge SHALL go directly to DONE with quotient=8'hFF, remainder=4'h0 and div_by_zero=1, and no RUN cycles.
REQ-019 Arithmetic SHALL be unsigned; the compare and subtract SHALL use a 5-bit partial remainder so no overflow occurs; the final remainder is the low 4 bits.
REQ-020 start asserted in RUN or DONE SHALL be ignored; it is not queued, and a start still high in the following IDLE cycle is accepted then.
REQ-021 busy SHALL equal (state==RUN); a divide-by-zero operation never asserts busy.
REQ-022 Input changes during RUN SHALL NOT affect the result in progress.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, with busy=0, done=0, quotient=8'h00, remainder=4'h0, div_by_zero=0, and clear all internal registers.
REQ-024 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the width constants (8, 4, 5) and the divide-by-zero quotient constant 8'hFF.
REQ-027 One combinational sub-module, div_step, SHALL implement a single shift/compare/subtract step, producing the next partial remainder and the quotient bit.
- bitdivider SHALL contain the FSM, the 3-bit step counter and the result registers.

Verification
REQ-028 200/7: start with 8'd200, 4'd7 -> busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
REQ-029 Multiplier inverse: 225/15 -> 15 r 0; 255/15 -> 17 r 0; 5/9 -> 0 r 5; 0/3 -> 0 r 0; each with done exactly 8 cycles after the accepting edge.
REQ-030 Divide by zero: 8'd77 / 4'd0 -> done on the next cycle, busy never high, quotient=8'hFF, remainder=0, div_by_zero=1.
REQ-031 Start during RUN: 100/3 running, then start held high with 50/5 mid-run -> first result 33 r 1. The held start is accepted in the following IDLE cycle -> 10 r 0.
REQ-032 Reset mid-run: rst_n pulsed low at step 4 of 200/7 -> all outputs zero immediately and no done. A fresh 9/2 afterwards -> 4 r 1.
REQ-033 Exhaustive self-check: all 256x15 nonzero-divisor pairs SHALL match the reference quotient and remainder, with latency checked on every operation.
